// File: rtl/alu_sequencer.sv
// Multi-cycle controller sequencing an external 8-bit ALU over a small register file with C/V/Z flags.
// Optional ADC instruction (extra EXEC2 pass) is enabled by defining ALU_SEQ_ADC_EN.
module alu_sequencer #(
  parameter  int NREGS = 4,
  localparam int RAW   = $clog2(NREGS)
) (
  input  logic           clk,
  input  logic           reset,
  // Handshake: an instruction transfers on a cycle where in_valid && in_ready;
  // in_ready is high only in IDLE, and in_valid while busy is ignored.
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [3:0]     in_op,
  input  logic [RAW-1:0] in_rd,
  input  logic [RAW-1:0] in_ra,
  input  logic [RAW-1:0] in_rb,
  input  logic [7:0]     in_imm,
  output logic [7:0]     alu_a,
  output logic [7:0]     alu_b,
  output logic [3:0]     alu_s,
  input  logic [7:0]     alu_r,
  input  logic           alu_c,
  input  logic           alu_v,
  output logic           done,
  output logic           err,
  output logic           flag_c,
  output logic           flag_v,
  output logic           flag_z,
  input  logic [RAW-1:0] dbg_sel,
  output logic [7:0]     dbg_data,
  output logic [2:0]     dbg_state
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_EXEC  = 3'd2;
  localparam logic [2:0] S_WB    = 3'd3;
`ifdef ALU_SEQ_ADC_EN
  localparam logic [2:0] S_EXEC2 = 3'd4;
`endif

  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_LDI = 4'b0001;
  localparam logic [3:0] OP_ADC = 4'b0110;
  localparam logic [3:0] OP_TST = 4'b0111;
  localparam logic [3:0] OP_MOV = 4'b1000;
  localparam logic [3:0] OP_ADD = 4'b1010;

  logic [2:0]     state_q, state_d;
  logic [3:0]     op_q, op_d;
  logic [RAW-1:0] rd_q, rd_d, ra_q, ra_d, rb_q, rb_d;
  logic [7:0]     imm_q, imm_d;
  logic [7:0]     a_q, a_d, b_q, b_d;
  logic [3:0]     s_q, s_d;
  logic [7:0]     res_q, res_d;
  logic           res_c_q, res_c_d, res_v_q, res_v_d;
  logic           c_q, c_d, v_q, v_d, z_q, z_d;
  logic [7:0]     rf_q [NREGS];
  logic           rf_we;
  logic [7:0]     rf_wdata;

  logic op_is_alu, op_is_adc, op_is_legal;

  // ALU opcodes are 1xxx plus TEST; they are forwarded to the ALU unchanged.
  assign op_is_alu = op_q[3] || (op_q == OP_TST);
`ifdef ALU_SEQ_ADC_EN
  assign op_is_adc = (op_q == OP_ADC);
`else
  assign op_is_adc = 1'b0;
`endif
  assign op_is_legal = op_is_alu || op_is_adc || (op_q == OP_LDI) || (op_q == OP_NOP);

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    rd_d     = rd_q;
    ra_d     = ra_q;
    rb_d     = rb_q;
    imm_d    = imm_q;
    a_d      = a_q;
    b_d      = b_q;
    s_d      = s_q;
    res_d    = res_q;
    res_c_d  = res_c_q;
    res_v_d  = res_v_q;
    c_d      = c_q;
    v_d      = v_q;
    z_d      = z_q;
    rf_we    = 1'b0;
    rf_wdata = res_q;
    case (state_q)
      S_IDLE: begin
        s_d = OP_MOV;
        if (in_valid) begin
          op_d    = in_op;
          rd_d    = in_rd;
          ra_d    = in_ra;
          rb_d    = in_rb;
          imm_d   = in_imm;
          state_d = S_READ;
        end
      end
      S_READ: begin
        a_d     = rf_q[ra_q];
        b_d     = rf_q[rb_q];
        s_d     = op_is_alu ? op_q : (op_is_adc ? OP_ADD : OP_MOV);
        state_d = S_EXEC;
      end
      S_EXEC: begin
        res_d   = alu_r;
        res_c_d = alu_c;
        res_v_d = alu_v;
        state_d = S_WB;
`ifdef ALU_SEQ_ADC_EN
        // Second ADD pass folds the incoming carry into the first-pass sum.
        if (op_is_adc) begin
          a_d     = alu_r;
          b_d     = {7'b0, c_q};
          state_d = S_EXEC2;
        end
`endif
      end
`ifdef ALU_SEQ_ADC_EN
      S_EXEC2: begin
        res_d   = alu_r;
        res_c_d = res_c_q | alu_c;
        res_v_d = res_v_q ^ alu_v;
        state_d = S_WB;
      end
`endif
      S_WB: begin
        state_d = S_IDLE;
        s_d     = OP_MOV;
        if (op_is_alu || op_is_adc) begin
          rf_we = 1'b1;
          c_d   = res_c_q;
          v_d   = res_v_q;
          z_d   = (res_q == 8'h00);
        end else if (op_q == OP_LDI) begin
          rf_we    = 1'b1;
          rf_wdata = imm_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= OP_NOP;
      rd_q    <= '0;
      ra_q    <= '0;
      rb_q    <= '0;
      imm_q   <= 8'h00;
      a_q     <= 8'h00;
      b_q     <= 8'h00;
      s_q     <= OP_MOV;
      res_q   <= 8'h00;
      res_c_q <= 1'b0;
      res_v_q <= 1'b0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
      z_q     <= 1'b0;
      for (int i = 0; i < NREGS; i++) rf_q[i] <= 8'h00;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      imm_q   <= imm_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      res_q   <= res_d;
      res_c_q <= res_c_d;
      res_v_q <= res_v_d;
      c_q     <= c_d;
      v_q     <= v_d;
      z_q     <= z_d;
      if (rf_we) rf_q[rd_q] <= rf_wdata;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign done      = (state_q == S_WB) && op_is_legal;
  assign err       = (state_q == S_WB) && !op_is_legal;
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_s     = s_q;
  assign flag_c    = c_q;
  assign flag_v    = v_q;
  assign flag_z    = z_q;
  assign dbg_data  = rf_q[dbg_sel];
  assign dbg_state = state_q;

endmodule
